// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard between decode and execute.
// Tracks the destination register of the instructions in EX, MEM and WB,
// returns per-operand bypass selects for the issuing instruction, stalls
// only on a load-use hazard against EX, and exposes a pending-write mask
// and a saturating count of stall cycles.
module fwd_scoreboard #(
    parameter int BITS  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      id_instr,
    input  logic             id_valid,
    input  logic             flush,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic             stall_o,
    output logic [BITS-1:0]  pending_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       is_load;
    } stage_t;

    stage_t           ex_q, mem_q, wb_q, ex_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic       wr_rd, use_rs1, use_rs2, is_load;
    logic [2:0] res_a, res_b;
    logic       unused_instr_bits;

    assign unused_instr_bits = ^{id_instr[31:25], id_instr[14:12]};

    // Returns {load_use, select}; the youngest matching stage wins.
    function automatic logic [2:0] resolve(input logic used, input logic [4:0] rs,
                                           input stage_t ex, input stage_t mem,
                                           input stage_t wb);
        logic [2:0] r;
        r = 3'b000;
        if (used && rs != 5'd0) begin
            if (ex.v && ex.rd == rs)        r = ex.is_load ? 3'b100 : 3'b001;
            else if (mem.v && mem.rd == rs) r = 3'b010;
            else if (wb.v && wb.rd == rs)   r = 3'b011;
        end
        return r;
    endfunction

    // Opcode decode: which register fields the issuing instruction uses.
    always_comb begin
        opcode  = id_instr[6:0];
        rd      = id_instr[11:7];
        rs1     = id_instr[19:15];
        rs2     = id_instr[24:20];
        wr_rd   = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        is_load = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL: wr_rd = 1'b1;
            OP_JALR:   begin wr_rd = 1'b1; use_rs1 = 1'b1; end
            OP_LOAD:   begin wr_rd = 1'b1; use_rs1 = 1'b1; is_load = 1'b1; end
            OP_IMM:    begin wr_rd = 1'b1; use_rs1 = 1'b1; end
            OP_OP:     begin wr_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_BRANCH, OP_STORE: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
            default: ;
        endcase
    end

    // Bypass selection, load-use stall and next EX entry / stall count.
    always_comb begin
        res_a   = resolve(id_valid & use_rs1, rs1, ex_q, mem_q, wb_q);
        res_b   = resolve(id_valid & use_rs2, rs2, ex_q, mem_q, wb_q);
        fwd_a_o = res_a[1:0];
        fwd_b_o = res_b[1:0];
        stall_o = id_valid & ~flush & (res_a[2] | res_b[2]);
        ex_d    = '0;
        if (id_valid && !stall_o && !flush && wr_rd && rd != 5'd0)
            ex_d = '{v: 1'b1, rd: rd, is_load: is_load};
        cnt_d = cnt_q;
        if (stall_o && cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // One-hot OR of the valid destinations still in flight.
    always_comb begin
        pending_o = '0;
        for (int i = 1; i < BITS; i++) begin
            pending_o[i] = (ex_q.v  && ex_q.rd  == 5'(i)) ||
                           (mem_q.v && mem_q.rd == 5'(i)) ||
                           (wb_q.v  && wb_q.rd  == 5'(i));
        end
    end

    assign stall_cnt_o = cnt_q;

    // Pipeline shift of the tracking entries and stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            cnt_q <= cnt_d;
        end
    end

endmodule
